// File: rtl/gemm_operand_loader.sv
// Stages GEMM operand rows popped from the scratchpad FIFO into input/weight/psum
// matrices and hands a complete set to the systolic array with a start/ready handshake.
module gemm_operand_loader #(
  parameter int ROWS         = 4,
  parameter int BITS_PER_ROW = 64,
  parameter int MAT_S_W      = 2,
  parameter int ROW_S_W      = 2
) (
  input  logic                                        CLK,
  input  logic                                        nRST,
  input  logic                                        gemmFIFO_empty,
  input  logic [BITS_PER_ROW+MAT_S_W+ROW_S_W+1:0]     gemmFIFO_rdata,
  output logic                                        gemmFIFO_REN,
  input  logic                                        array_ready,
  output logic                                        array_start,
  output logic                                        array_accumulate,
  output logic [ROWS*BITS_PER_ROW-1:0]                array_input,
  output logic [ROWS*BITS_PER_ROW-1:0]                array_weight,
  output logic [ROWS*BITS_PER_ROW-1:0]                array_psum,
  output logic                                        drop_err
);

  // state | meaning
  // LOAD  | popping rows into staging until every row of all three matrices is valid
  // ISSUE | array_start high, staging frozen, waiting for array_ready
  localparam int PKT_W = BITS_PER_ROW + MAT_S_W + ROW_S_W + 2;
  localparam int NSLOT = 3 * ROWS;

  typedef enum logic {LOAD, ISSUE} state_t;

  state_t state, stateNext;

  logic                    pktAcc;
  logic [MAT_S_W-1:0]      matSel;
  logic [ROW_S_W-1:0]      rowSel;
  logic [BITS_PER_ROW-1:0] pktData;
  logic                    matValid;
  logic                    unusedRsvd;
  logic [NSLOT-1:0]        valid;
  logic [NSLOT-1:0]        setMask;
  logic [NSLOT-1:0]        validMerged;

  assign unusedRsvd = gemmFIFO_rdata[PKT_W-1];
  assign pktAcc     = gemmFIFO_rdata[PKT_W-2];
  assign matSel     = gemmFIFO_rdata[BITS_PER_ROW+ROW_S_W +: MAT_S_W];
  assign rowSel     = gemmFIFO_rdata[BITS_PER_ROW +: ROW_S_W];
  assign pktData    = gemmFIFO_rdata[BITS_PER_ROW-1:0];
  assign matValid   = (matSel <= MAT_S_W'(2));

  assign array_start = (state == ISSUE);

  always_comb begin
    gemmFIFO_REN = 1'b0;
    stateNext    = state;
    setMask      = '0;
    if (nRST && state == LOAD) gemmFIFO_REN = !gemmFIFO_empty;
    for (int m = 0; m < 3; m++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (gemmFIFO_REN && matSel == MAT_S_W'(m) && rowSel == ROW_S_W'(r))
          setMask[m*ROWS+r] = 1'b1;
      end
    end
    // Include the row being popped this cycle so start follows the last pop by one cycle.
    validMerged = valid | setMask;
    case (state)
      LOAD:    if (&validMerged) stateNext = ISSUE;
      ISSUE:   if (array_ready)  stateNext = LOAD;
      default: stateNext = LOAD;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state            <= LOAD;
      valid            <= '0;
      array_input      <= '0;
      array_weight     <= '0;
      array_psum       <= '0;
      array_accumulate <= 1'b0;
      drop_err         <= 1'b0;
    end else begin
      state    <= stateNext;
      drop_err <= gemmFIFO_REN && !matValid;
      if (gemmFIFO_REN && matValid) array_accumulate <= pktAcc;
      for (int r = 0; r < ROWS; r++) begin
        if (setMask[r])          array_input [r*BITS_PER_ROW +: BITS_PER_ROW] <= pktData;
        if (setMask[ROWS+r])     array_weight[r*BITS_PER_ROW +: BITS_PER_ROW] <= pktData;
        if (setMask[2*ROWS+r])   array_psum  [r*BITS_PER_ROW +: BITS_PER_ROW] <= pktData;
      end
      // Staging data survives the handshake; only the bitmap forces a full reload.
      if (array_start && array_ready) valid <= '0;
      else                            valid <= validMerged;
    end
  end

endmodule
